dispatch_issue_queue: RTL

- Parametrised successor to the per-unit exec FIFOs fed by the dispatcher.
- Replaces strict in-order FIFO behaviour with a collapsing reservation-station queue. Each entry holds operand data and tags, and snoops the CDB so waiting entries capture their operands.
- Issues the oldest entry whose operands are both ready, so a ready instruction can issue past a stalled one.
- One instance per execution unit (int, ld/st, mult, div). Sits between dispatch packet generation and the execution unit.

---
 rtl/dispatch_issue_queue_if.sv | 54 +++++
 rtl/dispatch_issue_queue.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/dispatch_issue_queue_if.sv
// Dispatch/issue bundle for one execution-unit issue queue.
// master = dispatcher + execution-unit side, slave = the queue itself.
interface dispatch_issue_queue_if #(
  parameter int DEPTH     = 4,
  parameter int PAYLOAD_W = 16,
  parameter int TAG_W     = 6,
  parameter int DATA_W    = 32,
  parameter int CNT_W     = $clog2(DEPTH + 1)
);
  // dispatch side
  logic                 i_flush;
  logic                 i_disp_en;
  logic [PAYLOAD_W-1:0] i_disp_payload;
  logic                 i_rs1_pend;
  logic [TAG_W-1:0]     i_rs1_tag;
  logic [DATA_W-1:0]    i_rs1_data;
  logic                 i_rs2_pend;
  logic [TAG_W-1:0]     i_rs2_tag;
  logic [DATA_W-1:0]    i_rs2_data;
  logic [TAG_W-1:0]     i_rd_tag;
  // common data bus
  logic                 cdb_valid;
  logic [TAG_W-1:0]     cdb_tag;
  logic [DATA_W-1:0]    cdb_data;
  // occupancy
  logic                 o_full;
  logic                 o_empty;
  logic [CNT_W-1:0]     o_count;
  // issue side
  logic                 o_issue_valid;
  logic                 i_issue_ready;
  logic [PAYLOAD_W-1:0] o_issue_payload;
  logic [DATA_W-1:0]    o_issue_rs1_data;
  logic [DATA_W-1:0]    o_issue_rs2_data;
  logic [TAG_W-1:0]     o_issue_rd_tag;

  modport master (
    output i_flush, i_disp_en, i_disp_payload,
           i_rs1_pend, i_rs1_tag, i_rs1_data,
           i_rs2_pend, i_rs2_tag, i_rs2_data, i_rd_tag,
           cdb_valid, cdb_tag, cdb_data, i_issue_ready,
    input  o_full, o_empty, o_count, o_issue_valid,
           o_issue_payload, o_issue_rs1_data, o_issue_rs2_data, o_issue_rd_tag
  );

  modport slave (
    input  i_flush, i_disp_en, i_disp_payload,
           i_rs1_pend, i_rs1_tag, i_rs1_data,
           i_rs2_pend, i_rs2_tag, i_rs2_data, i_rd_tag,
           cdb_valid, cdb_tag, cdb_data, i_issue_ready,
    output o_full, o_empty, o_count, o_issue_valid,
           o_issue_payload, o_issue_rs1_data, o_issue_rs2_data, o_issue_rd_tag
  );
endinterface

// File: rtl/dispatch_issue_queue.sv
// Collapsing reservation-station issue queue for one execution unit.
// Slot 0 is oldest; valid entries stay packed from slot 0. Entries snoop the
// CDB for pending operands, and the oldest entry with both operands ready issues.
module dispatch_issue_queue #(
  parameter int DEPTH     = 4,
  parameter int PAYLOAD_W = 16,
  parameter int TAG_W     = 6,
  parameter int DATA_W    = 32,
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input logic                   i_clk,
  input logic                   i_rst,
  dispatch_issue_queue_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic [PAYLOAD_W-1:0] payload;
    logic                 rs1_pend;
    logic [TAG_W-1:0]     rs1_tag;
    logic [DATA_W-1:0]    rs1_data;
    logic                 rs2_pend;
    logic [TAG_W-1:0]     rs2_tag;
    logic [DATA_W-1:0]    rs2_data;
    logic [TAG_W-1:0]     rd_tag;
  } entry_t;

  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] ready;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, empty_q;
  logic [IDX_W-1:0] sel_idx;
  logic             any_ready;
  logic             issue_valid;
  logic             issue_fire;
  logic             disp_accept;
  entry_t           sel_ent;

  // Capture a broadcast value into any operand still waiting on that tag.
  function automatic entry_t snoop(entry_t e, logic hit_en,
                                   logic [TAG_W-1:0] tag, logic [DATA_W-1:0] data);
    entry_t r;
    r = e;
    if (hit_en && e.rs1_pend && (e.rs1_tag == tag)) begin
      r.rs1_pend = 1'b0;
      r.rs1_data = data;
    end
    if (hit_en && e.rs2_pend && (e.rs2_tag == tag)) begin
      r.rs2_pend = 1'b0;
      r.rs2_data = data;
    end
    return r;
  endfunction

  // Ready flags and lowest-index (oldest) ready pick, from registered state only.
  always_comb begin
    // NOTE: every comb output gets a default before the loop so no latch is inferred.
    ready     = '0;
    sel_idx   = '0;
    any_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      ready[i] = valid_q[i] && !ent_q[i].rs1_pend && !ent_q[i].rs2_pend;
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready[i]) begin
        sel_idx   = IDX_W'(i);
        any_ready = 1'b1;
      end
    end
  end

  assign issue_valid = any_ready && !bus.i_flush;
  assign issue_fire  = issue_valid && bus.i_issue_ready;
  assign disp_accept = bus.i_disp_en && !full_q && !bus.i_flush;
  assign sel_ent     = ent_q[sel_idx];

  assign bus.o_issue_valid    = issue_valid;
  assign bus.o_issue_payload  = issue_valid ? sel_ent.payload  : '0;
  assign bus.o_issue_rs1_data = issue_valid ? sel_ent.rs1_data : '0;
  assign bus.o_issue_rs2_data = issue_valid ? sel_ent.rs2_data : '0;
  assign bus.o_issue_rd_tag   = issue_valid ? sel_ent.rd_tag   : '0;
  assign bus.o_full           = full_q;
  assign bus.o_empty          = empty_q;
  assign bus.o_count          = count_q;

  // Next entry array: collapse over the issued slot, snoop the CDB, append the dispatch.
  always_comb begin
    entry_t new_ent;
    int     src;
    int     wr_idx;
    logic   keep;
    new_ent = '{payload:  bus.i_disp_payload,
                rs1_pend: bus.i_rs1_pend, rs1_tag: bus.i_rs1_tag, rs1_data: bus.i_rs1_data,
                rs2_pend: bus.i_rs2_pend, rs2_tag: bus.i_rs2_tag, rs2_data: bus.i_rs2_data,
                rd_tag:   bus.i_rd_tag};
    new_ent = snoop(new_ent, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
    // The append slot moves down by one when an older entry leaves this cycle.
    wr_idx  = int'(count_q) - (issue_fire ? 1 : 0);
    for (int i = 0; i < DEPTH; i++) begin
      if (issue_fire && (i >= int'(sel_idx))) begin
        src  = (i < DEPTH - 1) ? i + 1 : i;
        keep = (i < DEPTH - 1) && valid_q[src];
      end else begin
        src  = i;
        keep = valid_q[i];
      end
      ent_d[i]   = snoop(ent_q[src], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
      valid_d[i] = keep;
      if (disp_accept && (i == wr_idx)) begin
        ent_d[i]   = new_ent;
        valid_d[i] = 1'b1;
      end
    end
    if (bus.i_flush) begin
      valid_d = '0;
    end
  end

  // Occupancy next state: a full-queue dispatch is never accepted, so no overflow.
  always_comb begin
    if (bus.i_flush) begin
      count_d = '0;
    end else begin
      count_d = count_q + CNT_W'(disp_accept) - CNT_W'(issue_fire);
    end
  end

  // Control state with synchronous reset; flags registered from the next count.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (i_rst) begin
      valid_q <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  // Entry storage.
  always_ff @(posedge i_clk) begin
    // NOTE: entry contents are not reset; the valid bits alone give them meaning.
    ent_q <= ent_d;
  end
endmodule
